// File: rtl/mem_data_memory_ws_pkg.sv
// Shared definitions for the MEM-stage data memory.
//  - funct3 encodings for loads and stores
//  - FSM state type
//  - byte-lane enable type
//  - is_illegal(): request legality check used by the top level
package mem_data_memory_ws_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    typedef logic [3:0] lane_en_t;

    // ctrl is {MemRead, MemWrite}. Only meaningful when ctrl != 0.
    function automatic logic is_illegal(input logic [1:0] ctrl,
                                        input logic [2:0] f3,
                                        input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (ctrl == 2'b11) begin
            bad = 1'b1;
        end
        case (f3)
            F3_B, F3_BU: bad = bad;
            F3_H, F3_HU: if (addr_lo[0]) bad = 1'b1;
            F3_W:        if (addr_lo != 2'b00) bad = 1'b1;
            default:     bad = 1'b1;
        endcase
        // Stores have no unsigned variants.
        if (ctrl == 2'b01 && f3[2]) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_data_memory_ws_if.sv
// Pipeline <-> data memory bus.
//  i_ctrlMEM   {MemRead, MemWrite}
//  i_funct3    access size / extension
//  i_memAddr   byte address
//  i_writeData store data
//  o_readData  extended load result
//  o_stall     freeze request to the pipeline
//  o_valid     access completed this cycle
//  o_fault     illegal or misaligned request
//  o_spyAddr   latched address (debug)
//  o_spyData   store data / load result (debug)
interface mem_data_memory_ws_if;

    logic [1:0]  i_ctrlMEM;
    logic [2:0]  i_funct3;
    logic [31:0] i_memAddr;
    logic [31:0] i_writeData;
    logic [31:0] o_readData;
    logic        o_stall;
    logic        o_valid;
    logic        o_fault;
    logic [31:0] o_spyAddr;
    logic [31:0] o_spyData;

    modport master (
        output i_ctrlMEM, i_funct3, i_memAddr, i_writeData,
        input  o_readData, o_stall, o_valid, o_fault, o_spyAddr, o_spyData
    );

    modport slave (
        input  i_ctrlMEM, i_funct3, i_memAddr, i_writeData,
        output o_readData, o_stall, o_valid, o_fault, o_spyAddr, o_spyData
    );

endinterface

// File: rtl/mem_data_memory_ws_lane_align.sv
// Combinational byte-lane steering for the data memory.
//  funct3_i   access size / extension
//  addr_lo_i  byte offset within the word
//  wdata_i    raw store data
//  rword_i    raw word read from the array
//  byte_en_o  per-lane write enables
//  wdata_o    store data replicated onto every lane it may land on
//  rdata_o    selected and extended load result
module mem_lane_align
    import mem_data_memory_ws_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output lane_en_t    byte_en_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  rbyte [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_rbyte
        assign rbyte[gi] = rword_i[8*gi +: 8];
    end

    assign byte_sel = rbyte[addr_lo_i];
    assign half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

    always_comb begin
        byte_en_o = 4'b1111;
        wdata_o   = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                byte_en_o = 4'b0001 << addr_lo_i;
                wdata_o   = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                byte_en_o = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o   = {2{wdata_i[15:0]}};
            end
            default: begin
                byte_en_o = 4'b1111;
                wdata_o   = wdata_i;
            end
        endcase
    end

    always_comb begin
        rdata_o = rword_i;
        case (funct3_i)
            F3_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata_o = {24'b0, byte_sel};
            F3_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata_o = {16'b0, half_sel};
            default: rdata_o = rword_i;
        endcase
    end

endmodule

// File: rtl/mem_data_memory_ws.sv
// MEM-stage data memory with configurable wait states.
//  i_clk      clock
//  i_reset_n  asynchronous active-low reset
//  bus        slave side of mem_data_memory_ws_if
// A legal request stalls the pipeline for LATENCY+1 cycles, then o_valid
// pulses for one cycle. Illegal requests raise o_fault without touching state.
module mem_data_memory_ws
    import mem_data_memory_ws_pkg::*;
#(
    parameter int DEPTH_WORDS = 2048,
    parameter int LATENCY     = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    mem_data_memory_ws_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        funct3_q;
    logic              is_write_q;
    logic [31:0]       read_data_q;

    logic              req;
    logic              fault_req;
    logic              start;
    logic              access_fire;
    logic              we;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic [31:0]       rword;
    lane_en_t          byte_en;
    logic [31:0]       wdata_rep;
    logic [31:0]       load_ext;

    logic              stall;
    logic              valid;
    logic              fault;
    logic [31:0]       spy_data;

    // Exactly one of MemRead/MemWrite requests an access; 2'b11 is a fault.
    assign req       = ^bus.i_ctrlMEM;
    assign fault_req = (bus.i_ctrlMEM != 2'b00) &&
                       is_illegal(bus.i_ctrlMEM, bus.i_funct3, bus.i_memAddr[1:0]);
    assign start     = (state_q == ST_IDLE) && req && !fault_req;

    assign access_fire = (state_q == ST_WAIT) && (cnt_q == '0);
    assign we          = access_fire && is_write_q;
    assign wr_idx      = addr_q[IDX_W+1:2];

    // The read port is addressed from the live bus in IDLE so the word is
    // already registered when the request enters WAIT; afterwards it tracks
    // the latched address. This keeps a registered read with no extra cycle.
    assign rd_idx = (state_q == ST_IDLE) ? bus.i_memAddr[IDX_W+1:2] : addr_q[IDX_W+1:2];

    // One narrow array per byte lane so partial writes map onto plain RAMs.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH_WORDS];
        logic [7:0] rd_byte_q;

        always_ff @(posedge i_clk) begin
            if (we && byte_en[gi]) begin
                lane_mem[wr_idx] <= wdata_rep[8*gi +: 8];
            end
            rd_byte_q <= lane_mem[rd_idx];
        end

        assign rword[8*gi +: 8] = rd_byte_q;
    end

    mem_lane_align u_lane_align (
        .funct3_i  (funct3_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rword_i   (rword),
        .byte_en_o (byte_en),
        .wdata_o   (wdata_rep),
        .rdata_o   (load_ext)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(LATENCY - 1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latches, wait counter and load result
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            funct3_q    <= '0;
            is_write_q  <= 1'b0;
            read_data_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (start) begin
                addr_q     <= bus.i_memAddr;
                wdata_q    <= bus.i_writeData;
                funct3_q   <= bus.i_funct3;
                is_write_q <= bus.i_ctrlMEM[0];
            end
            if (access_fire && !is_write_q) begin
                read_data_q <= load_ext;
            end
        end
    end

    // Outputs
    always_comb begin
        stall    = 1'b0;
        valid    = 1'b0;
        fault    = 1'b0;
        spy_data = '0;
        case (state_q)
            ST_IDLE: begin
                stall = start;
                fault = fault_req;
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (is_write_q) spy_data = wdata_q;
            end
            ST_DONE: begin
                valid    = 1'b1;
                spy_data = is_write_q ? wdata_q : read_data_q;
            end
            default: stall = 1'b0;
        endcase
    end

    assign bus.o_stall    = stall;
    assign bus.o_valid    = valid;
    assign bus.o_fault    = fault;
    assign bus.o_readData = read_data_q;
    assign bus.o_spyAddr  = addr_q;
    assign bus.o_spyData  = spy_data;

endmodule
